// File: rtl/s12_bit_subtractor_pkg.sv
// Shared constants and types for the 12-bit subtractor.
// Holds the default width and the packed status-flag bundle.
package s12_bit_subtractor_pkg;

  localparam int WIDTH_DEF = 12;

  typedef struct packed {
    logic borrow;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/s12_bit_subtractor_full_subtractor_cell.sv
// One-bit full-subtractor cell of the ripple-borrow chain.
// Ports: i_a, i_b, i_bin in; o_d difference, o_bout borrow out.
module full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_d    = w_axb ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/s12_bit_subtractor.sv
// WIDTH-bit subtractor x - y: combinational diff/borrow plus a registered stage.
// Ports: clk, rst (async high), x, y, en; borrow, diff; diff_q + flags, valid_q.
module s12_bit_subtractor
  import s12_bit_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             en,
  output logic             borrow,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] diff_q,
  output logic             borrow_q,
  output logic             zero_q,
  output logic             neg_q,
  output logic             ovf_q,
  output logic             valid_q
);

  logic [WIDTH:0]   w_bc;
  logic [WIDTH-1:0] w_diff;
  flags_t           w_flags;

  logic [WIDTH-1:0] r_diff;
  flags_t           r_flags;
  logic             r_valid;

  assign w_bc[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .i_a    (x[i]),
      .i_b    (y[i]),
      .i_bin  (w_bc[i]),
      .o_d    (w_diff[i]),
      .o_bout (w_bc[i+1])
    );
  end

  // Overflow: operands of opposite sign and result sign differs from x.
  always_comb begin
    w_flags        = '0;
    w_flags.borrow = w_bc[WIDTH];
    w_flags.zero   = (w_diff == '0);
    w_flags.neg    = w_diff[WIDTH-1];
    w_flags.ovf    = (x[WIDTH-1] != y[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != x[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff  <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_diff  <= w_diff;
        r_flags <= w_flags;
      end
    end
  end

  assign diff     = w_diff;
  assign borrow   = w_bc[WIDTH];
  assign diff_q   = r_diff;
  assign borrow_q = r_flags.borrow;
  assign zero_q   = r_flags.zero;
  assign neg_q    = r_flags.neg;
  assign ovf_q    = r_flags.ovf;
  assign valid_q  = r_valid;

endmodule

// File: tb/tb_s12_bit_subtractor.sv
// Self-checking bench for s12_bit_subtractor.
// Random and directed x/y against an arithmetic model.
module tb_s12_bit_subtractor;

  localparam int W = 12;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x, y;
  logic         en;
  logic         borrow;
  logic [W-1:0] diff;
  logic [W-1:0] diff_q;
  logic         borrow_q, zero_q, neg_q, ovf_q, valid_q;

  int checks = 0;
  int failures = 0;

  int e_dq, e_bq, e_zq, e_nq, e_oq, e_vq;

  always #5 clk = ~clk;

  s12_bit_subtractor dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .en       (en),
    .borrow   (borrow),
    .diff     (diff),
    .diff_q   (diff_q),
    .borrow_q (borrow_q),
    .zero_q   (zero_q),
    .neg_q    (neg_q),
    .ovf_q    (ovf_q),
    .valid_q  (valid_q)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sval(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, ".diff_q"}, int'(diff_q), e_dq);
    chk({tag, ".borrow_q"}, int'(borrow_q), e_bq);
    chk({tag, ".zero_q"}, int'(zero_q), e_zq);
    chk({tag, ".neg_q"}, int'(neg_q), e_nq);
    chk({tag, ".ovf_q"}, int'(ovf_q), e_oq);
    chk({tag, ".valid_q"}, int'(valid_q), e_vq);
  endtask

  task automatic clr_model();
    e_dq = 0; e_bq = 0; e_zq = 0;
    e_nq = 0; e_oq = 0; e_vq = 0;
  endtask

  task automatic step(input string tag, input int a, input int b,
                      input bit e);
    int d, s, b_exp;
    @(negedge clk);
    x = W'(a); y = W'(b); en = e;
    #1;
    d = (a - b) & MASK;
    b_exp = (a < b) ? 1 : 0;
    chk({tag, ".diff"}, int'(diff), d);
    chk({tag, ".borrow"}, int'(borrow), b_exp);
    if (e) begin
      s = sval(a) - sval(b);
      e_dq = d;
      e_bq = b_exp;
      e_zq = (d == 0) ? 1 : 0;
      e_nq = (d >> (W - 1)) & 1;
      e_oq = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
    end
    e_vq = e ? 1 : 0;
    @(posedge clk);
    #1;
    chk_regs(tag);
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; en = 1'b1;
    clr_model();
    #1;
    chk_regs("reset");
    @(posedge clk); #1;
    chk_regs("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    step("d45_28", 45, 28, 1'b1);
    step("d5_9", 5, 9, 1'b1);
    step("d800_1", 'h800, 'h001, 1'b1);
    step("d800_800", 'h800, 'h800, 1'b1);
    step("d0_fff", 'h000, 'hFFF, 1'b1);
    step("hold", 'h123, 'h045, 1'b0);
    step("dfff_1", 'hFFF, 'h001, 1'b1);

    #2;
    rst = 1'b1;
    #1;
    clr_model();
    chk_regs("async_rst");
    chk("async_rst.diff", int'(diff), 'hFFE);
    chk("async_rst.borrow", int'(borrow), 0);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_regs("rel_en0");

    for (int i = 0; i < 10000; i++) begin
      step("rand", int'($urandom_range(MASK, 0)),
           int'($urandom_range(MASK, 0)), 1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s12_bit_subtractor.md
Name: s12_bit_subtractor

Overview:
- 12-bit two's-complement/unsigned subtractor computing x - y.
- It has a combinational result path plus a registered output stage with status flags.
- It serves as the datapath subtractor of the 6-bit restoring divider. The divider consumes the combinational outputs within the same evaluation, so the combinational path must settle with no clock edge.
- The registered copies serve clocked consumers.

Parameters:
- WIDTH, 12, operand/result width in bits; all widths below scale with it (minimum 2).

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  WIDTH  minuend.
- y  input  WIDTH  subtrahend.
- en  input  1  capture enable for the registered stage.
- borrow  output  1  combinational borrow-out: 1 iff x < y, unsigned.
- diff  output  WIDTH  combinational (x - y) mod 2^WIDTH.
- diff_q  output  WIDTH  registered diff.
- borrow_q  output  1  registered borrow.
- zero_q  output  1  registered: diff == 0.
- neg_q  output  1  registered: diff[WIDTH-1].
- ovf_q  output  1  registered signed overflow.
- valid_q  output  1  registered: 1 in the cycle after a capture.

Behaviour:
- Combinational path:
  - diff = x + ~y + 1, truncated to WIDTH bits.
  - borrow = NOT carry-out of that sum, i.e. 1 iff x < y unsigned.
  - Purely combinational, no latches; it responds to any change of x or y with no clock dependency.
  - It is unaffected by rst and en.
- Structure: ripple-borrow chain of WIDTH 1-bit full-subtractor cells.
  - Cell i: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
  - Chain borrow-in of bit 0 is 0.
  - The chain result must equal the arithmetic definition above bit-for-bit.
- Signed overflow (ovf) = (x[MSB] != y[MSB]) && (diff[MSB] != x[MSB]).
- Registered stage:
  - On a rising clk with en=1: diff_q, borrow_q, zero_q, neg_q and ovf_q capture the current combinational values; valid_q <= 1.
  - With en=0: the data registers hold; valid_q <= 0.
- Reset:
  - rst=1 immediately (asynchronously) forces diff_q=0, borrow_q=0, zero_q=0, neg_q=0, ovf_q=0, valid_q=0.
  - Registers stay cleared while rst is high, regardless of en.
  - The first capture occurs on the first rising edge after rst deasserts with en=1.
  - Reset asserted mid-operation discards any pending capture; combinational outputs keep tracking x/y.
- Latency: combinational outputs 0 cycles; registered outputs 1 cycle after the en-qualified edge.
- Boundaries:
  - x == y gives diff=0, borrow=0, zero=1.
  - x=0, y=all-ones gives diff=1, borrow=1.
  - Inputs containing X/Z are not supported; no defined behaviour is required.

Decomposition:
- Shared package: WIDTH default constant and a flags typedef {borrow, zero, neg, ovf}.
- One natural sub-module: full_subtractor_cell (1-bit d/bout), instantiated WIDTH times via generate.
- Flag logic and registers stay in the top module.

Test Plan:
- x=45, y=28 (7<<2, a divider step): diff=17, borrow=0. With en=1, one edge later diff_q=17, zero_q=0, valid_q=1.
- x=5, y=9: diff=0xFFC, borrow=1. Registered: neg_q=1, ovf_q=0.
- x=0x800, y=0x001: diff=0x7FF, borrow=0, ovf_q=1, neg_q=0. Then x=y=0x800: diff=0, zero_q=1.
- Capture x=0xFFF, y=0x001 (diff_q=0xFFE), then assert rst asynchronously between edges: all registered outputs read 0 before the next edge while diff still reads 0xFFE. Release rst with en=0: registers remain 0 and valid_q=0.
- Random sweep of 10k x/y pairs comparing diff/borrow to a (x - y) / (x < y) model. Toggle en randomly and check registered outputs against the previous-cycle model.
